// File: rtl/data_mem_responder.sv
// Multicycle 64-bit data-memory responder for the core's load/store path.
// One request is accepted at a time over a valid/ready handshake; the access runs
// against an internal doubleword array and a one-cycle response pulse is returned a
// fixed number of cycles after acceptance. Misaligned and out-of-range accesses are
// flagged on resp_err and never touch the array.
module data_mem_responder #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IdxW  = ADDR_W - 3;
  localparam int unsigned Depth = 2 ** IdxW;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeDbl  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Architectural state
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;

  // Captured request
  logic        cap_we_q, cap_we_d;
  logic [1:0]  cap_size_q, cap_size_d;
  logic [63:0] cap_addr_q, cap_addr_d;
  logic [63:0] cap_wdata_q, cap_wdata_d;

  // Storage; intentionally not cleared by reset
  logic [63:0] mem_q [Depth];

  // Effective request and datapath
  logic            accept;
  logic            go_resp;
  logic            cur_we;
  logic [1:0]      cur_size;
  logic [63:0]     cur_addr;
  logic [63:0]     cur_wdata;
  logic [IdxW-1:0] idx;
  logic [5:0]      shamt;
  logic            range_err;
  logic            align_err;
  logic            err;
  logic [63:0]     size_mask;
  logic [63:0]     lane_mask;
  logic [63:0]     rd_word;
  logic [63:0]     load_data;
  logic [63:0]     wr_word;
  logic            mem_we;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign accept = (state_q == StIdle) && req_ready_q && req_valid;

  // With LATENCY=1 the access completes straight out of IDLE, before the capture
  // registers are loaded, so the live request is used while idle.
  always_comb begin
    if (state_q == StIdle) begin
      cur_we    = req_we;
      cur_size  = req_size;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = cap_we_q;
      cur_size  = cap_size_q;
      cur_addr  = cap_addr_q;
      cur_wdata = cap_wdata_q;
    end
  end

  assign idx   = cur_addr[ADDR_W-1:3];
  assign shamt = {cur_addr[2:0], 3'b000};

  // Error decode: any address bit above the decoded window, or a lane crossing.
  always_comb begin
    range_err = ((cur_addr >> ADDR_W) != 64'd0);
    align_err = 1'b0;
    size_mask = 64'h0000_0000_0000_00ff;
    unique case (cur_size)
      SizeByte: begin
        align_err = 1'b0;
        size_mask = 64'h0000_0000_0000_00ff;
      end
      SizeHalf: begin
        align_err = cur_addr[0];
        size_mask = 64'h0000_0000_0000_ffff;
      end
      SizeWord: begin
        align_err = |cur_addr[1:0];
        size_mask = 64'h0000_0000_ffff_ffff;
      end
      SizeDbl: begin
        align_err = |cur_addr[2:0];
        size_mask = 64'hffff_ffff_ffff_ffff;
      end
      default: begin
        align_err = 1'b1;
        size_mask = 64'd0;
      end
    endcase
    err = range_err | align_err;
  end

  // Little-endian lane extract for loads and read-modify-write merge for stores.
  always_comb begin
    rd_word   = mem_q[idx];
    load_data = (rd_word >> shamt) & size_mask;
    lane_mask = size_mask << shamt;
    wr_word   = (rd_word & ~lane_mask) | ((cur_wdata << shamt) & lane_mask);
  end

  // Next-state logic for the FSM and its registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_we_d     = cap_we_q;
    cap_size_d   = cap_size_q;
    cap_addr_d   = cap_addr_q;
    cap_wdata_d  = cap_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    go_resp      = 1'b0;
    mem_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cap_we_d    = req_we;
          cap_size_d  = req_size;
          cap_addr_d  = req_addr;
          cap_wdata_d = req_wdata;
          if (LATENCY == 1) begin
            go_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q <= 4'd1) begin
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // The edge entering RESP commits the store and registers the load result so
    // that data, error and valid all appear together for the RESP cycle.
    if (go_resp) begin
      state_d      = StResp;
      cnt_d        = 4'd0;
      resp_valid_d = 1'b1;
      resp_err_d   = err;
      resp_rdata_d = (cur_we || err) ? 64'd0 : load_data;
      mem_we       = cur_we && !err;
    end

    req_ready_d = (state_d == StIdle);
  end

  // FSM state, capture registers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 64'd0;
      cap_we_q     <= 1'b0;
      cap_size_q   <= 2'b00;
      cap_addr_q   <= 64'd0;
      cap_wdata_q  <= 64'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      cap_we_q     <= cap_we_d;
      cap_size_q   <= cap_size_d;
      cap_addr_q   <= cap_addr_d;
      cap_wdata_q  <= cap_wdata_d;
    end
  end

  // Array write port; state_q is forced to IDLE under reset, so an aborted store never lands.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 1, 15) share one
// set of request wires; sel picks which one sees req_valid and whose outputs are observed.
module tb_data_mem_responder;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  int          sel;

  logic        rv    [3];
  logic        rdy   [3];
  logic        vld   [3];
  logic [63:0] rdat  [3];
  logic        rerr  [3];

  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int total;
  int bad;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[15];

  always_comb begin
    for (int i = 0; i < 3; i++) rv[i] = req_valid && (sel == i);
    req_ready  = rdy[sel];
    resp_valid = vld[sel];
    resp_rdata = rdat[sel];
    resp_err   = rerr[sel];
  end

  data_mem_responder #(.ADDR_W(16), .LATENCY(2)) u_dut_l2 (
    .clock(clock), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld[0]), .resp_rdata(rdat[0]), .resp_err(rerr[0])
  );

  data_mem_responder #(.ADDR_W(16), .LATENCY(1)) u_dut_l1 (
    .clock(clock), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld[1]), .resp_rdata(rdat[1]), .resp_err(rerr[1])
  );

  data_mem_responder #(.ADDR_W(16), .LATENCY(15)) u_dut_l15 (
    .clock(clock), .reset(reset), .req_valid(rv[2]), .req_ready(rdy[2]),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld[2]), .resp_rdata(rdat[2]), .resp_err(rerr[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input int s);
    if (s == 1) return 1;
    if (s == 2) return 15;
    return 2;
  endfunction

  // Wait for ready, issue one request, then check response timing, data and handshake.
  task automatic do_req(input logic we, input logic [1:0] size, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp_rdata,
                        input logic exp_err, input string tag);
    int n;
    int lat;
    bit timing_ok;
    lat = lat_of(sel);
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({tag, " ready_wait"}, {63'd0, req_ready}, 64'd1);
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    timing_ok = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clock);
      if (resp_valid !== (k == lat)) timing_ok = 1'b0;
      if (k == lat) begin
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " err"}, {63'd0, resp_err}, {63'd0, exp_err});
        check({tag, " ready_in_resp"}, {63'd0, req_ready}, 64'd0);
      end
    end
    check({tag, " timing"}, {63'd0, timing_ok}, 64'd1);
    @(negedge clock);
    check({tag, " ready_after"}, {63'd0, req_ready}, 64'd1);
    check({tag, " valid_after"}, {63'd0, resp_valid}, 64'd0);
    check({tag, " rdata_hold"}, resp_rdata, exp_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit abort_ok;
    total     = 0;
    bad       = 0;
    sel       = 0;
    reset     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b11;
    req_addr  = 64'h40;
    req_wdata = 64'd0;

    // Store/load table for the LATENCY=2 instance
    vecs[0]  = '{1'b1, 2'b11, 64'h40,    64'h0123_4567_89ab_cdef, 64'd0, 1'b0};
    vecs[1]  = '{1'b0, 2'b11, 64'h40,    64'd0, 64'h0123_4567_89ab_cdef, 1'b0};
    vecs[2]  = '{1'b1, 2'b00, 64'h43,    64'h1122_3344_5566_77aa, 64'd0, 1'b0};
    vecs[3]  = '{1'b0, 2'b11, 64'h40,    64'd0, 64'h0123_4567_aaab_cdef, 1'b0};
    vecs[4]  = '{1'b0, 2'b01, 64'h42,    64'd0, 64'h0000_0000_0000_aaab, 1'b0};
    vecs[5]  = '{1'b0, 2'b10, 64'h42,    64'd0, 64'd0, 1'b1};
    vecs[6]  = '{1'b1, 2'b11, 64'h41,    64'hffff_ffff_ffff_ffff, 64'd0, 1'b1};
    vecs[7]  = '{1'b0, 2'b11, 64'h40,    64'd0, 64'h0123_4567_aaab_cdef, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 64'h10000, 64'd0, 64'd0, 1'b1};
    vecs[9]  = '{1'b0, 2'b00, 64'h41,    64'd0, 64'h0000_0000_0000_00cd, 1'b0};
    vecs[10] = '{1'b1, 2'b01, 64'h46,    64'h0000_0000_1234_beef, 64'd0, 1'b0};
    vecs[11] = '{1'b0, 2'b11, 64'h40,    64'd0, 64'hbeef_4567_aaab_cdef, 1'b0};
    vecs[12] = '{1'b1, 2'b11, 64'h80,    64'h1111_2222_3333_4444, 64'd0, 1'b0};
    vecs[13] = '{1'b0, 2'b10, 64'h84,    64'd0, 64'h0000_0000_1111_2222, 1'b0};
    vecs[14] = '{1'b0, 2'b00, 64'h8000_0000_0000_0080, 64'd0, 64'd0, 1'b1};

    // Reset held with a request pending
    repeat (3) @(negedge clock);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset ready[%0d]", s), {63'd0, rdy[s]}, 64'd0);
      check($sformatf("reset valid[%0d]", s), {63'd0, vld[s]}, 64'd0);
    end
    check("reset rdata", resp_rdata, 64'd0);
    check("reset err", {63'd0, resp_err}, 64'd0);
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    check("ready before first edge", {63'd0, req_ready}, 64'd0);
    @(negedge clock);
    check("ready after first edge", {63'd0, req_ready}, 64'd1);

    for (int i = 0; i < 15; i++) begin
      do_req(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
             vecs[i].err, $sformatf("vec%0d", i));
    end

    // Abort a store to 0x80 by asserting reset while it is in WAIT
    req_we    = 1'b1;
    req_size  = 2'b11;
    req_addr  = 64'h80;
    req_wdata = 64'hdead_beef_dead_beef;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    abort_ok = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (resp_valid !== 1'b0) abort_ok = 1'b0;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (resp_valid !== 1'b0) abort_ok = 1'b0;
    end
    check("abort no_resp", {63'd0, abort_ok}, 64'd1);
    do_req(1'b0, 2'b11, 64'h80, 64'd0, 64'h1111_2222_3333_4444, 1'b0, "abort reload");

    // Latency sweep on the other instances
    sel = 1;
    @(negedge clock);
    do_req(1'b1, 2'b11, 64'h40, 64'h0123_4567_89ab_cdef, 64'd0, 1'b0, "l1 store");
    do_req(1'b0, 2'b11, 64'h40, 64'd0, 64'h0123_4567_89ab_cdef, 1'b0, "l1 load");
    do_req(1'b0, 2'b01, 64'h43, 64'd0, 64'd0, 1'b1, "l1 misalign");
    sel = 2;
    @(negedge clock);
    do_req(1'b1, 2'b11, 64'h40, 64'h0123_4567_89ab_cdef, 64'd0, 1'b0, "l15 store");
    do_req(1'b0, 2'b11, 64'h40, 64'd0, 64'h0123_4567_89ab_cdef, 1'b0, "l15 load");
    do_req(1'b0, 2'b10, 64'h44, 64'd0, 64'h0000_0000_0123_4567, 1'b0, "l15 word");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
